// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the round-robin stream multiplexer: default sizes
// and the select-width helper used by the interface, arbiter and top.
package stream_mux_pkg;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 4;

  // Width of a channel index; never collapses to zero bits for a single channel.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Bundle of the N input streams plus the single output stream of the mux.
// The mux uses the slave view; the producers/consumer side uses master.
interface stream_mux_rr_if
  import stream_mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF
);
  localparam int SEL_W = sel_w(N_CH);

  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_last;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic [SEL_W-1:0]  out_sel;
  logic              out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Rotating-priority arbiter. Owns the round-robin pointer; the scan starts
// one past the last granted channel. A hold input forces the grant to a
// caller-supplied index (used for packet lock).
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = N_CH_DEF
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic                  hold,
  input  logic [sel_w(N)-1:0]   lock_idx,
  input  logic                  advance,
  output logic [sel_w(N)-1:0]   gnt_idx,
  output logic                  gnt_any
);
  localparam int SEL_W = sel_w(N);

  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_cand [N];
  logic [SEL_W-1:0] w_scan_idx;
  logic             w_scan_any;

  // Candidate k is (ptr + k + 1) mod N. The sum is formed one bit wider so it
  // cannot alias, and a single subtract wraps it since the sum is below 2N.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      logic [SEL_W:0] w_sum;
      assign w_sum = {1'b0, r_ptr} + (SEL_W+1)'(gi + 1);
      assign w_cand[gi] = (w_sum >= (SEL_W+1)'(N)) ? SEL_W'(w_sum - (SEL_W+1)'(N))
                                                   : SEL_W'(w_sum);
    end
  endgenerate

  // Priority scan: walking from the farthest candidate back lets the nearest
  // requesting candidate overwrite the result last.
  always_comb begin
    w_scan_idx = r_ptr;
    w_scan_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[w_cand[k]]) begin
        w_scan_idx = w_cand[k];
        w_scan_any = 1'b1;
      end
    end
  end

  assign gnt_idx = hold ? lock_idx : w_scan_idx;
  assign gnt_any = hold | w_scan_any;

  // Pointer follows every accepted beat; reset to N-1 so channel 0 leads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= SEL_W'(N - 1);
    end else if (advance) begin
      r_ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 round-robin stream multiplexer with a registered output stage and an
// optional packet lock that keeps the grant until the last beat is taken.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int W        = W_DEF,
  parameter bit PKT_MODE = 1'b0
)(
  input  logic          clk,
  input  logic          rst,
  stream_mux_rr_if.slave bus
);
  localparam int SEL_W = sel_w(N_CH);

  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic             r_out_last;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_lock;
  logic [SEL_W-1:0] r_lock_idx;

  logic             w_en;
  logic             w_xfer;
  logic             w_gnt_any;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [N_CH-1:0]  w_ready;
  logic [W-1:0]     w_ch_data [N_CH];

  // The output register can load when empty or being drained this cycle;
  // nothing is offered while reset is held.
  assign w_en = !rst && (!r_out_valid || bus.out_ready);

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.in_valid),
    .hold     (r_lock),
    .lock_idx (r_lock_idx),
    .advance  (w_xfer),
    .gnt_idx  (w_gnt_idx),
    .gnt_any  (w_gnt_any)
  );

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_ch_data[gi] = bus.in_data[gi*W +: W];
      assign w_ready[gi]   = w_en && w_gnt_any && (w_gnt_idx == SEL_W'(gi));
    end
  endgenerate

  assign w_xfer        = |(bus.in_valid & w_ready);
  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_sel   = r_out_sel;

  // Output stage: load on accept, clear valid when drained with nothing new.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ch_data[w_gnt_idx];
      r_out_last  <= bus.in_last[w_gnt_idx];
      r_out_sel   <= w_gnt_idx;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Packet lock: a non-last beat pins the grant, a last beat releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_xfer && PKT_MODE) begin
      r_lock     <= !bus.in_last[w_gnt_idx];
      r_lock_idx <= w_gnt_idx;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: one instance per PKT_MODE, sharing clk/rst.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.N_CH(N), .W(W)) bus0 ();
  stream_mux_rr_if #(.N_CH(N), .W(W)) bus1 ();

  stream_mux_rr #(.N_CH(N), .W(W), .PKT_MODE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  stream_mux_rr #(.N_CH(N), .W(W), .PKT_MODE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int vectors = 0;
  int errors  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.in_valid = 4'hF; bus0.in_data = 16'h1234; bus0.in_last = 4'h0; bus0.out_ready = 1'b1;
    bus1.in_valid = 4'hF; bus1.in_data = 16'h5678; bus1.in_last = 4'h0; bus1.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      $display("reset clk %0d: v0=%b r0=%b d0=%h v1=%b r1=%b d1=%h", c,
               bus0.out_valid, bus0.in_ready, bus0.out_data, bus1.out_valid, bus1.in_ready, bus1.out_data);
      vectors++;
      if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 4'h0 || bus0.out_data !== 4'h0 || bus0.out_sel !== 2'd0) begin
        errors++;
        $display("FAIL reset_dut0 clk %0d: got v=%b rdy=%b d=%h sel=%0d, need v=0 rdy=0000 d=0 sel=0",
                 c, bus0.out_valid, bus0.in_ready, bus0.out_data, bus0.out_sel);
      end
      vectors++;
      if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 4'h0 || bus1.out_data !== 4'h0 || bus1.out_last !== 1'b0) begin
        errors++;
        $display("FAIL reset_dut1 clk %0d: got v=%b rdy=%b d=%h last=%b, need v=0 rdy=0000 d=0 last=0",
                 c, bus1.out_valid, bus1.in_ready, bus1.out_data, bus1.out_last);
      end
    end
    bus0.in_valid = 4'h0;
    bus1.in_valid = 4'h0;
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel;
    logic [3:0] exp_data;
    logic [3:0] exp_rdy;
    bus0.in_valid = 4'hF; bus0.in_data = 16'hDCBA; bus0.in_last = 4'h0;
    #1;
    vectors++;
    if (bus0.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rr_first_ready: got %b need 0001", bus0.in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_sel  = 2'(k % 4);
      exp_data = 4'hA + 4'(exp_sel);
      $display("rr beat %0d: sel=%0d data=%h", k, bus0.out_sel, bus0.out_data);
      vectors++;
      if (bus0.out_valid !== 1'b1 || bus0.out_sel !== exp_sel || bus0.out_data !== exp_data) begin
        errors++;
        $display("FAIL rr_beat %0d: got v=%b sel=%0d d=%h need v=1 sel=%0d d=%h",
                 k, bus0.out_valid, bus0.out_sel, bus0.out_data, exp_sel, exp_data);
      end
      if (k < 4) begin
        exp_rdy = 4'b0001 << ((k + 1) % 4);
        vectors++;
        if (bus0.in_ready !== exp_rdy) begin
          errors++;
          $display("FAIL rr_ready %0d: got %b need %b", k, bus0.in_ready, exp_rdy);
        end
      end
    end
    bus0.in_valid = 4'h0;
    tick();
    $display("rr drain: v=%b", bus0.out_valid);
    vectors++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: got v=%b need 0", bus0.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus0.in_valid = 4'b0010; bus0.in_data = 16'h0050;
    tick();
    $display("bp load: sel=%0d data=%h", bus0.out_sel, bus0.out_data);
    vectors++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 4'h5 || bus0.out_sel !== 2'd1) begin
      errors++;
      $display("FAIL bp_load: got v=%b d=%h sel=%0d need v=1 d=5 sel=1", bus0.out_valid, bus0.out_data, bus0.out_sel);
    end
    bus0.out_ready = 1'b0;
    bus0.in_data   = 16'h0060;
    for (int c = 0; c < 3; c++) begin
      #1;
      $display("bp stall %0d: rdy=%b data=%h", c, bus0.in_ready, bus0.out_data);
      vectors++;
      if (bus0.in_ready !== 4'h0 || bus0.out_valid !== 1'b1 || bus0.out_data !== 4'h5 || bus0.out_sel !== 2'd1) begin
        errors++;
        $display("FAIL bp_stall %0d: got rdy=%b v=%b d=%h sel=%0d need rdy=0000 v=1 d=5 sel=1",
                 c, bus0.in_ready, bus0.out_valid, bus0.out_data, bus0.out_sel);
      end
      tick();
    end
    bus0.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus0.in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_ready: got %b need 0010", bus0.in_ready);
    end
    tick();
    $display("bp next: data=%h", bus0.out_data);
    vectors++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 4'h6) begin
      errors++;
      $display("FAIL bp_next: got v=%b d=%h need v=1 d=6", bus0.out_valid, bus0.out_data);
    end
    bus0.in_valid = 4'h0;
    tick();
    vectors++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got v=%b need 0", bus0.out_valid);
    end
  endtask

  task automatic test_single_channel();
    logic [3:0] exp_data;
    bus0.in_valid = 4'b1000;
    for (int b = 0; b < 4; b++) begin
      exp_data = 4'(7 + b);
      bus0.in_data = {exp_data, 12'h000};
      tick();
      $display("single beat %0d: v=%b sel=%0d data=%h", b, bus0.out_valid, bus0.out_sel, bus0.out_data);
      vectors++;
      if (bus0.out_valid !== 1'b1 || bus0.out_sel !== 2'd3 || bus0.out_data !== exp_data) begin
        errors++;
        $display("FAIL single_beat %0d: got v=%b sel=%0d d=%h need v=1 sel=3 d=%h",
                 b, bus0.out_valid, bus0.out_sel, bus0.out_data, exp_data);
      end
    end
    bus0.in_valid = 4'hF; bus0.in_data = 16'h3210;
    #1;
    vectors++;
    if (bus0.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_ready: got %b need 0001", bus0.in_ready);
    end
    tick();
    $display("wrap beat: sel=%0d data=%h", bus0.out_sel, bus0.out_data);
    vectors++;
    if (bus0.out_sel !== 2'd0 || bus0.out_data !== 4'h0) begin
      errors++;
      $display("FAIL wrap_beat: got sel=%0d d=%h need sel=0 d=0", bus0.out_sel, bus0.out_data);
    end
    bus0.in_valid = 4'h0;
    tick();
  endtask

  task automatic test_packet_lock();
    bus1.in_valid = 4'b0010; bus1.in_data = 16'h0010; bus1.in_last = 4'b0010;
    tick();
    $display("pkt ch1 beat: sel=%0d data=%h last=%b", bus1.out_sel, bus1.out_data, bus1.out_last);
    vectors++;
    if (bus1.out_sel !== 2'd1 || bus1.out_data !== 4'h1 || bus1.out_last !== 1'b1) begin
      errors++;
      $display("FAIL pkt_ch1: got sel=%0d d=%h last=%b need sel=1 d=1 last=1", bus1.out_sel, bus1.out_data, bus1.out_last);
    end
    bus1.in_valid = 4'b0101; bus1.in_data = 16'h020E; bus1.in_last = 4'b0001;
    #1;
    vectors++;
    if (bus1.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL pkt_first_ready: got %b need 0100", bus1.in_ready);
    end
    tick();
    $display("pkt beat 0: sel=%0d data=%h last=%b", bus1.out_sel, bus1.out_data, bus1.out_last);
    vectors++;
    if (bus1.out_sel !== 2'd2 || bus1.out_data !== 4'h2 || bus1.out_last !== 1'b0) begin
      errors++;
      $display("FAIL pkt_beat0: got sel=%0d d=%h last=%b need sel=2 d=2 last=0", bus1.out_sel, bus1.out_data, bus1.out_last);
    end
    bus1.in_data = 16'h030E;
    tick();
    $display("pkt beat 1: sel=%0d data=%h", bus1.out_sel, bus1.out_data);
    vectors++;
    if (bus1.out_sel !== 2'd2 || bus1.out_data !== 4'h3) begin
      errors++;
      $display("FAIL pkt_beat1: got sel=%0d d=%h need sel=2 d=3", bus1.out_sel, bus1.out_data);
    end
    bus1.in_valid = 4'b0001;
    #1;
    vectors++;
    if (bus1.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL pkt_idle_lock_ready: got %b need 0100", bus1.in_ready);
    end
    tick();
    vectors++;
    if (bus1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pkt_idle_bubble: got v=%b need 0", bus1.out_valid);
    end
    bus1.in_valid = 4'b0101; bus1.in_data = 16'h040E; bus1.in_last = 4'b0101;
    tick();
    $display("pkt beat 2: sel=%0d data=%h last=%b", bus1.out_sel, bus1.out_data, bus1.out_last);
    vectors++;
    if (bus1.out_sel !== 2'd2 || bus1.out_data !== 4'h4 || bus1.out_last !== 1'b1) begin
      errors++;
      $display("FAIL pkt_beat2: got sel=%0d d=%h last=%b need sel=2 d=4 last=1", bus1.out_sel, bus1.out_data, bus1.out_last);
    end
    bus1.in_valid = 4'b0001;
    #1;
    vectors++;
    if (bus1.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL pkt_release_ready: got %b need 0001", bus1.in_ready);
    end
    tick();
    $display("pkt ch0 beat: sel=%0d data=%h", bus1.out_sel, bus1.out_data);
    vectors++;
    if (bus1.out_sel !== 2'd0 || bus1.out_data !== 4'hE || bus1.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pkt_ch0: got v=%b sel=%0d d=%h need v=1 sel=0 d=e", bus1.out_valid, bus1.out_sel, bus1.out_data);
    end
    bus1.in_valid = 4'h0;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    bus1.in_valid = 4'b0010; bus1.in_data = 16'h0090; bus1.in_last = 4'b0000;
    tick();
    $display("mid-pkt lock beat: sel=%0d data=%h", bus1.out_sel, bus1.out_data);
    vectors++;
    if (bus1.out_sel !== 2'd1 || bus1.out_data !== 4'h9 || bus1.out_last !== 1'b0) begin
      errors++;
      $display("FAIL midpkt_lock: got sel=%0d d=%h last=%b need sel=1 d=9 last=0", bus1.out_sel, bus1.out_data, bus1.out_last);
    end
    bus1.in_valid = 4'b0011; bus1.in_data = 16'h00A6; bus1.in_last = 4'b0001;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus1.in_ready !== 4'h0) begin
      errors++;
      $display("FAIL midpkt_rst_ready: got %b need 0000", bus1.in_ready);
    end
    tick();
    rst = 1'b0;
    $display("mid-pkt after rst: v=%b sel=%0d data=%h", bus1.out_valid, bus1.out_sel, bus1.out_data);
    vectors++;
    if (bus1.out_valid !== 1'b0 || bus1.out_sel !== 2'd0 || bus1.out_data !== 4'h0 || bus1.out_last !== 1'b0) begin
      errors++;
      $display("FAIL midpkt_rst_state: got v=%b sel=%0d d=%h last=%b need all 0",
               bus1.out_valid, bus1.out_sel, bus1.out_data, bus1.out_last);
    end
    #1;
    vectors++;
    if (bus1.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midpkt_post_ready: got %b need 0001", bus1.in_ready);
    end
    tick();
    $display("mid-pkt first beat: sel=%0d data=%h", bus1.out_sel, bus1.out_data);
    vectors++;
    if (bus1.out_valid !== 1'b1 || bus1.out_sel !== 2'd0 || bus1.out_data !== 4'h6) begin
      errors++;
      $display("FAIL midpkt_first: got v=%b sel=%0d d=%h need v=1 sel=0 d=6", bus1.out_valid, bus1.out_sel, bus1.out_data);
    end
    bus1.in_valid = 4'h0;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single_channel();
    test_packet_lock();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
